// File: rtl/fu_share_if.sv
// Requester/arbiter bundle for a shared multiplier: packed per-requester
// operands and grants, plus a shared result bus tagged by a one-hot strobe.
interface fu_share_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic [3:0]             inflight;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, inflight, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, inflight, busy
    );
endinterface

// File: rtl/fu_share_arbiter.sv
// Round-robin sharing of one LAT-deep pipelined multiplier among N_REQ
// requesters; results return tagged to the issuing requester.
module fu_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int LAT   = 3
) (
    input logic       clk,
    input logic       reset,
    fu_share_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             hs;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [LAT-1:0]   vld_p;
    logic [PW-1:0]    tag_p  [LAT];
    logic [WIDTH-1:0] prod_p [LAT];
    logic [3:0]       inflight_r;

    function automatic logic [WIDTH-1:0] mul_wrap(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] full;
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return full[WIDTH-1:0];
    endfunction

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        int            c;
        logic [PW-1:0] cidx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        c       = 0;
        cidx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= N_REQ) c = c - N_REQ;
            cidx = PW'(c);
            if (!gnt_any && bus.req_valid[cidx]) begin
                gnt_any = 1'b1;
                gnt_idx = cidx;
            end
        end
    end

    assign hs = gnt_any & reset;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (hs) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Stage 1 captures the product at issue; later stages shift it towards
    // the output, and data only moves with a valid op so the last stage
    // holds the previous result between strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p      <= '0;
            inflight_r <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_p[k]  <= '0;
                prod_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= hs;
            if (hs) begin
                tag_p[0]  <= gnt_idx;
                prod_p[0] <= mul_wrap(a_sel, b_sel);
            end
            for (int k = 1; k < LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) begin
                    tag_p[k]  <= tag_p[k-1];
                    prod_p[k] <= prod_p[k-1];
                end
            end
            inflight_r <= inflight_r + {3'b000, hs} - {3'b000, vld_p[LAT-1]};
        end
    end

    // Output stage: the last pipeline register drives the result bus.
    always_comb begin
        bus.rsp_valid = '0;
        if (vld_p[LAT-1]) bus.rsp_valid[tag_p[LAT-1]] = 1'b1;
    end

    assign bus.rsp_data = prod_p[LAT-1];
    assign bus.inflight = inflight_r;
    assign bus.busy     = (inflight_r != 4'd0) || (|bus.req_valid);
endmodule

// File: tb/tb_fu_share_arbiter.sv
// Directed plus randomized bench for fu_share_arbiter against a queue-based
// model of grants, scheduled results and occupancy.
module tb_fu_share_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int LAT   = 3;

    typedef struct {
        int               due;
        int               tag;
        logic [WIDTH-1:0] data;
    } op_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    bit   chk_en;

    op_t              q[$];
    int               cyc;
    int               mptr;
    logic [WIDTH-1:0] mlast;
    logic [N_REQ-1:0] hs_mask;

    fu_share_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bif ();

    fu_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Grant = valid requester at the smallest forward distance from the pointer.
    function automatic int model_grant(input logic [N_REQ-1:0] v, input int p);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                d = (i - p + N_REQ) % N_REQ;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Model update on each rising edge.
    initial begin
        cyc     = 0;
        mptr    = 0;
        mlast   = '0;
        hs_mask = '0;
        forever begin
            @(posedge clk);
            cyc++;
            hs_mask = '0;
            if (!reset) begin
                q.delete();
                mptr  = 0;
                mlast = '0;
            end else begin
                int g;
                g = model_grant(bif.req_valid, mptr);
                if (g >= 0) begin
                    op_t     o;
                    longint  pa;
                    longint  pb;
                    pa     = longint'(bif.req_a[g*WIDTH +: WIDTH]);
                    pb     = longint'(bif.req_b[g*WIDTH +: WIDTH]);
                    o.due  = cyc + LAT - 1;
                    o.tag  = g;
                    o.data = WIDTH'((pa * pb) % (longint'(1) << WIDTH));
                    q.push_back(o);
                    hs_mask[g] = 1'b1;
                    mptr = (g + 1) % N_REQ;
                end
                while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
                if (q.size() > 0 && q[0].due == cyc) mlast = q[0].data;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [N_REQ-1:0] exp_rdy;
                logic [N_REQ-1:0] exp_rv;
                int               g;
                exp_rdy = '0;
                exp_rv  = '0;
                g = model_grant(bif.req_valid, mptr);
                if (reset && g >= 0) exp_rdy[g] = 1'b1;
                if (q.size() > 0 && q[0].due == cyc) exp_rv[q[0].tag] = 1'b1;
                chk("req_ready", 32'(bif.req_ready), 32'(exp_rdy));
                chk("rsp_valid", 32'(bif.rsp_valid), 32'(exp_rv));
                chk("rsp_data",  32'(bif.rsp_data),  32'(mlast));
                chk("inflight",  32'(bif.inflight),  32'(q.size()));
                chk("busy",      32'(bif.busy),
                    32'((q.size() != 0) || (bif.req_valid != '0)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        bif.req_valid[i]           = v;
        bif.req_a[i*WIDTH +: WIDTH] = a;
        bif.req_b[i*WIDTH +: WIDTH] = b;
    endtask

    initial begin
        int exp_g[5];
        n_cmp  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        reset  = 1'b0;
        bif.req_valid = N_REQ'($urandom);
        bif.req_a     = '0;
        bif.req_b     = '0;
        tick();
        chk_en = 1'b1;

        // Reset with random request activity.
        for (int k = 0; k < 3; k++) begin
            bif.req_valid = N_REQ'($urandom);
            @(negedge clk);
            chk("rst_ready", 32'(bif.req_ready), 32'h0);
            chk("rst_rspv",  32'(bif.rsp_valid), 32'h0);
            chk("rst_data",  32'(bif.rsp_data),  32'h0);
            chk("rst_infl",  32'(bif.inflight),  32'h0);
            tick();
        end
        bif.req_valid = '0;
        reset = 1'b1;
        tick();

        // Single requester 2: 7*6.
        set_req(2, 1'b1, 16'd7, 16'd6);
        @(negedge clk);
        chk("single_ready", 32'(bif.req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 16'd7, 16'd6);
        @(negedge clk);
        chk("single_infl", 32'(bif.inflight), 32'd1);
        tick();
        @(negedge clk);
        chk("single_early", 32'(bif.rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("single_rspv", 32'(bif.rsp_valid), 32'h4);
        chk("single_data", 32'(bif.rsp_data),  32'd42);
        tick();
        @(negedge clk);
        chk("single_once", 32'(bif.rsp_valid), 32'h0);
        chk("single_hold", 32'(bif.rsp_data),  32'd42);
        tick();

        // All four continuously valid from ptr=0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_g = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, WIDTH'(i + 1), 16'd10);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 5) chk("rr_grant", 32'(bif.req_ready), 32'(1) << exp_g[k]);
            if (k >= 3 && k <= 6) begin
                chk("rr_rspv", 32'(bif.rsp_valid), 32'(1) << (k - 3));
                chk("rr_data", 32'(bif.rsp_data),  32'(10 * (k - 2)));
            end
            tick();
        end
        bif.req_valid = '0;
        repeat (4) tick();

        // Wrap: grant 2, then only 3 and 0 compete.
        set_req(2, 1'b1, 16'd1, 16'd1);
        tick();
        set_req(2, 1'b0, 16'd1, 16'd1);
        set_req(3, 1'b1, 16'd3, 16'd3);
        set_req(0, 1'b1, 16'd5, 16'd5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wrap_grant", 32'(bif.req_ready), (k % 2 == 0) ? 32'h8 : 32'h1);
            tick();
        end
        bif.req_valid = '0;
        repeat (4) tick();

        // Truncating product.
        set_req(1, 1'b1, 16'hFFFF, 16'h0002);
        tick();
        set_req(1, 1'b0, 16'hFFFF, 16'h0002);
        tick();
        tick();
        @(negedge clk);
        chk("ovf_rspv", 32'(bif.rsp_valid), 32'h2);
        chk("ovf_data", 32'(bif.rsp_data),  32'hFFFE);
        tick();

        // Reset while operations are in flight.
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, WIDTH'(i + 3), 16'd9);
        repeat (3) tick();
        reset = 1'b0;
        bif.req_valid = '0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_rspv", 32'(bif.rsp_valid), 32'h0);
            chk("midrst_infl", 32'(bif.inflight),  32'h0);
            tick();
        end
        bif.req_valid = '1;
        @(negedge clk);
        chk("midrst_ptr", 32'(bif.req_ready), 32'h1);
        tick();
        bif.req_valid = '0;
        repeat (4) tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [N_REQ-1:0] v;
            tick();
            v = bif.req_valid;
            reset = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (v[i] && hs_mask[i]) v[i] = 1'b0;
                if (!v[i] && $urandom_range(0, 99) < 55) begin
                    v[i] = 1'b1;
                    bif.req_a[i*WIDTH +: WIDTH] = rand_op();
                    bif.req_b[i*WIDTH +: WIDTH] = rand_op();
                end
            end
            bif.req_valid = v;
        end
        reset = 1'b1;
        bif.req_valid = '0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
